// File: rtl/stack_alu_pkg.sv
// Shared opcode/state encodings and helpers for the stack ALU.
// Optional multiplier is enabled by defining STACK_ALU_MUL_EN.
package stack_alu_pkg;

    localparam int unsigned OP_WIDTH = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_NEG = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_EQ  = 4'd9,
        OP_LTU = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A,
        WAIT_B,
        EXEC,
        DONE
    } state_e;

    // Unary ops pop only one operand (A).
    function automatic logic is_unary(input op_e op);
        return (op == OP_NOT) || (op == OP_NEG);
    endfunction

endpackage

// File: rtl/stack_alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, DATA_WIDTH cycles.
// done_c_o/product_c_o are combinational and valid in the final iteration
// cycle, so the caller can register the product on the same edge.
module stack_alu_mul_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic                      done_c_o,
    output logic [2*DATA_WIDTH-1:0]   product_c_o
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;

    // Accumulate the current partial product.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign done_c_o    = busy_q && (cnt_q == CW'(DATA_WIDTH - 1));
    assign product_c_o = acc_d;

    // Load operands on start, then iterate once per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= PW'(b_i);
            mplier_q <= a_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stack_alu.sv
// Stack-machine ALU: pops A (TOS) then B, computes B op A, registers result.
// Define STACK_ALU_MUL_EN to build in the multi-cycle MUL opcode.
module stack_alu
    import stack_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  OP_START,
    input  logic [OP_WIDTH-1:0]   OP_CODE,
    input  logic [DATA_WIDTH-1:0] OPERAND_IN,
    input  logic                  OPERAND_VALID,
    output logic [DATA_WIDTH-1:0] ULA_OUT,
    output logic                  ULA_DONE,
    output logic                  ULA_BUSY,
    output logic                  FLAG_ZERO,
    output logic                  FLAG_CARRY,
    output logic                  ERR_OP
);

`ifdef STACK_ALU_MUL_EN
    localparam logic [OP_WIDTH-1:0] LAST_OP = OP_MUL;
`else
    localparam logic [OP_WIDTH-1:0] LAST_OP = OP_LTU;
`endif

    state_e                state_q;
    op_e                   op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  done_q;
    logic                  zero_q;
    logic                  carry_q;
    logic                  err_q;

    logic [DATA_WIDTH:0]   sum_c;
    logic [DATA_WIDTH-1:0] exec_out_c;
    logic                  exec_carry_c;
    logic                  exec_ready_c;

`ifdef STACK_ALU_MUL_EN
    logic                    mul_start_c;
    logic                    mul_done_c;
    logic [2*DATA_WIDTH-1:0] mul_product_c;

    assign mul_start_c = (state_q == WAIT_B) && OPERAND_VALID && (op_q == OP_MUL);

    stack_alu_mul_seq #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk         (clk),
        .reset       (reset),
        .start_i     (mul_start_c),
        .a_i         (a_q),
        .b_i         (OPERAND_IN),
        .done_c_o    (mul_done_c),
        .product_c_o (mul_product_c)
    );
`endif

    // Result and carry for the latched opcode; MUL overrides when built in.
    always_comb begin
        sum_c        = {1'b0, b_q} + {1'b0, a_q};
        exec_out_c   = '0;
        exec_carry_c = 1'b0;
        exec_ready_c = 1'b1;
        case (op_q)
            OP_ADD: begin
                exec_out_c   = sum_c[DATA_WIDTH-1:0];
                exec_carry_c = sum_c[DATA_WIDTH];
            end
            OP_SUB: begin
                exec_out_c   = b_q - a_q;
                exec_carry_c = (b_q < a_q);
            end
            OP_AND: exec_out_c = b_q & a_q;
            OP_OR:  exec_out_c = b_q | a_q;
            OP_XOR: exec_out_c = b_q ^ a_q;
            OP_NOT: exec_out_c = ~a_q;
            OP_NEG: exec_out_c = '0 - a_q;
            OP_SHL: exec_out_c = (32'(a_q) >= DATA_WIDTH) ? '0 : (b_q << a_q);
            OP_SHR: exec_out_c = (32'(a_q) >= DATA_WIDTH) ? '0 : (b_q >> a_q);
            OP_EQ:  exec_out_c = DATA_WIDTH'(b_q == a_q);
            OP_LTU: exec_out_c = DATA_WIDTH'(b_q < a_q);
            default: exec_out_c = '0;
        endcase
`ifdef STACK_ALU_MUL_EN
        if (op_q == OP_MUL) begin
            exec_out_c   = mul_product_c[DATA_WIDTH-1:0];
            exec_carry_c = |mul_product_c[2*DATA_WIDTH-1:DATA_WIDTH];
            exec_ready_c = mul_done_c;
        end
`endif
    end

    // Control FSM with registered result, flags and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (OP_START) begin
                        if (OP_CODE <= LAST_OP) begin
                            op_q    <= op_e'(OP_CODE);
                            err_q   <= 1'b0;
                            state_q <= WAIT_A;
                        end else begin
                            out_q   <= '0;
                            zero_q  <= 1'b1;
                            carry_q <= 1'b0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WAIT_A: begin
                    if (OPERAND_VALID) begin
                        a_q     <= OPERAND_IN;
                        state_q <= is_unary(op_q) ? EXEC : WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (OPERAND_VALID) begin
                        b_q     <= OPERAND_IN;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_ready_c) begin
                        out_q   <= exec_out_c;
                        zero_q  <= (exec_out_c == '0);
                        carry_q <= exec_carry_c;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ULA_OUT    = out_q;
    assign ULA_DONE   = done_q;
    assign ULA_BUSY   = (state_q != IDLE);
    assign FLAG_ZERO  = zero_q;
    assign FLAG_CARRY = carry_q;
    assign ERR_OP     = err_q;

endmodule

// File: tb/tb_stack_alu.sv
// Directed self-checking bench for stack_alu (DATA_WIDTH = 8).
// Expected MUL behaviour follows STACK_ALU_MUL_EN.
module tb_stack_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       OP_START = 1'b0;
    logic [3:0] OP_CODE = 4'd0;
    logic [7:0] OPERAND_IN = 8'd0;
    logic       OPERAND_VALID = 1'b0;
    logic [7:0] ULA_OUT;
    logic       ULA_DONE, ULA_BUSY, FLAG_ZERO, FLAG_CARRY, ERR_OP;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    stack_alu #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .OP_START      (OP_START),
        .OP_CODE       (OP_CODE),
        .OPERAND_IN    (OPERAND_IN),
        .OPERAND_VALID (OPERAND_VALID),
        .ULA_OUT       (ULA_OUT),
        .ULA_DONE      (ULA_DONE),
        .ULA_BUSY      (ULA_BUSY),
        .FLAG_ZERO     (FLAG_ZERO),
        .FLAG_CARRY    (FLAG_CARRY),
        .ERR_OP        (ERR_OP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       carry;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] op);
        OP_START = 1'b1;
        OP_CODE  = op;
        tick();
        OP_START = 1'b0;
    endtask

    task automatic give(input logic [7:0] v);
        OPERAND_VALID = 1'b1;
        OPERAND_IN    = v;
        tick();
        OPERAND_VALID = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1]  = '{4'd3,  8'hF0, 8'h0C, 8'hFC, 1'b0};
        vecs[2]  = '{4'd4,  8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[3]  = '{4'd6,  8'h01, 8'h00, 8'hFF, 1'b0};
        vecs[4]  = '{4'd7,  8'h03, 8'h81, 8'h08, 1'b0};
        vecs[5]  = '{4'd7,  8'h08, 8'hFF, 8'h00, 1'b0};
        vecs[6]  = '{4'd8,  8'h01, 8'h80, 8'h40, 1'b0};
        vecs[7]  = '{4'd8,  8'h09, 8'hFF, 8'h00, 1'b0};
        vecs[8]  = '{4'd9,  8'h05, 8'h05, 8'h01, 1'b0};
        vecs[9]  = '{4'd9,  8'h05, 8'h06, 8'h00, 1'b0};
        vecs[10] = '{4'd10, 8'h05, 8'h03, 8'h01, 1'b0};
        vecs[11] = '{4'd10, 8'h03, 8'h05, 8'h00, 1'b0};
        vecs[12] = '{4'd0,  8'h01, 8'hFF, 8'h00, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_out",   16'(ULA_OUT),  16'h00);
        check("rst_done",  16'(ULA_DONE), 16'h0);
        check("rst_busy",  16'(ULA_BUSY), 16'h0);
        check("rst_zero",  16'(FLAG_ZERO), 16'h0);
        check("rst_carry", 16'(FLAG_CARRY), 16'h0);
        check("rst_err",   16'(ERR_OP),   16'h0);
        reset = 1'b0;

        // ADD immediately after reset release: 0xFE + 0x05
        start_op(4'd0);
        check("add_busy", 16'(ULA_BUSY), 16'h1);
        give(8'h05);
        give(8'hFE);
        check("add_n1_done", 16'(ULA_DONE), 16'h0);
        tick();
        check("add_done",  16'(ULA_DONE),   16'h1);
        check("add_out",   16'(ULA_OUT),    16'h03);
        check("add_carry", 16'(FLAG_CARRY), 16'h1);
        check("add_zero",  16'(FLAG_ZERO),  16'h0);
        tick();
        check("add_done_pulse", 16'(ULA_DONE), 16'h0);
        check("add_idle",       16'(ULA_BUSY), 16'h0);
        check("add_hold",       16'(ULA_OUT),  16'h03);

        // SUB with borrow: 0x03 - 0x07
        start_op(4'd1);
        give(8'h07);
        give(8'h03);
        tick();
        check("sub1_out",   16'(ULA_OUT),    16'hFC);
        check("sub1_carry", 16'(FLAG_CARRY), 16'h1);
        tick();

        // SUB to zero
        start_op(4'd1);
        give(8'h03);
        give(8'h03);
        tick();
        check("sub2_out",   16'(ULA_OUT),    16'h00);
        check("sub2_zero",  16'(FLAG_ZERO),  16'h1);
        check("sub2_carry", 16'(FLAG_CARRY), 16'h0);
        tick();

        // NOT with a stray operand during EXEC
        start_op(4'd5);
        give(8'h0F);
        OPERAND_VALID = 1'b1;
        OPERAND_IN    = 8'hAA;
        tick();
        OPERAND_VALID = 1'b0;
        check("not_done", 16'(ULA_DONE), 16'h1);
        check("not_out",  16'(ULA_OUT),  16'hF0);
        tick();
        check("not_idle", 16'(ULA_BUSY), 16'h0);
        tick();
        check("not_no_consume", 16'(ULA_BUSY), 16'h0);

        // MUL: 0x11 * 0x10
        start_op(4'd11);
`ifdef STACK_ALU_MUL_EN
        give(8'h10);
        give(8'h11);
        check("mul_n1_done", 16'(ULA_DONE), 16'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("mul_wait_done", 16'(ULA_DONE), 16'h0);
        end
        tick();
        check("mul_done",  16'(ULA_DONE),   16'h1);
        check("mul_out",   16'(ULA_OUT),    16'h10);
        check("mul_carry", 16'(FLAG_CARRY), 16'h1);
        check("mul_err",   16'(ERR_OP),     16'h0);
`else
        check("mul_done", 16'(ULA_DONE), 16'h1);
        check("mul_err",  16'(ERR_OP),   16'h1);
        check("mul_out",  16'(ULA_OUT),  16'h00);
`endif
        tick();

        // Invalid opcode 0xF: done and error one cycle after start
        start_op(4'hF);
        check("inv_done", 16'(ULA_DONE),  16'h1);
        check("inv_err",  16'(ERR_OP),    16'h1);
        check("inv_out",  16'(ULA_OUT),   16'h00);
        check("inv_zero", 16'(FLAG_ZERO), 16'h1);
        tick();
        check("inv_err_hold", 16'(ERR_OP),   16'h1);
        check("inv_idle",     16'(ULA_BUSY), 16'h0);

        // OP_START while busy is ignored; accepted start clears ERR_OP
        start_op(4'd0);
        check("busy_err_clr", 16'(ERR_OP), 16'h0);
        OP_START = 1'b1;
        OP_CODE  = 4'hF;
        give(8'h01);
        OP_START = 1'b0;
        check("busy_ign_done", 16'(ULA_DONE), 16'h0);
        give(8'h02);
        tick();
        check("busy_ign_out", 16'(ULA_OUT), 16'h03);
        check("busy_ign_err", 16'(ERR_OP),  16'h0);
        tick();

        // Table of remaining ops
        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].op);
            give(vecs[i].a);
            if (vecs[i].op != 4'd5 && vecs[i].op != 4'd6) give(vecs[i].b);
            tick();
            check($sformatf("vec%0d_done", i),  16'(ULA_DONE),   16'h1);
            check($sformatf("vec%0d_out", i),   16'(ULA_OUT),    16'(vecs[i].out));
            check($sformatf("vec%0d_carry", i), 16'(FLAG_CARRY), 16'(vecs[i].carry));
            check($sformatf("vec%0d_zero", i),  16'(FLAG_ZERO),  16'(vecs[i].out == 8'h00));
            tick();
        end

        // Reset while waiting for B
        start_op(4'd0);
        give(8'h40);
        check("rstb_busy_pre", 16'(ULA_BUSY), 16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstb_busy", 16'(ULA_BUSY), 16'h0);
        check("rstb_out",  16'(ULA_OUT),  16'h00);
        check("rstb_done", 16'(ULA_DONE), 16'h0);
        start_op(4'd0);
        give(8'h20);
        give(8'h30);
        tick();
        check("rstb_add_done",  16'(ULA_DONE),   16'h1);
        check("rstb_add_out",   16'(ULA_OUT),    16'h50);
        check("rstb_add_carry", 16'(FLAG_CARRY), 16'h0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stack_alu.md
STACK_ALU -- requirements
Module: stack_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of operands and result.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port OP_START  input  1  one-cycle request to begin an operation.
REQ-005 SHALL have port OP_CODE  input  4  operation, sampled with OP_START.
REQ-006 SHALL have port OPERAND_IN  input  DATA_WIDTH  operand from the stack read register.
REQ-007 SHALL have port OPERAND_VALID  input  1  OPERAND_IN is valid this cycle.
REQ-008 SHALL have port ULA_OUT  output  DATA_WIDTH  registered result, fed to stack write mux input 0.
REQ-009 SHALL have ports ULA_DONE, ULA_BUSY, FLAG_ZERO, FLAG_CARRY, ERR_OP  output  1 each.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_A, WAIT_B, EXEC, DONE; ULA_BUSY = (state != IDLE).
REQ-011 SHALL accept OP_START only in IDLE; OP_START in any other state is ignored.
REQ-012 SHALL, on an accepted valid opcode, latch OP_CODE and go to WAIT_A.
REQ-013 SHALL, on an invalid opcode, go directly to DONE with ERR_OP=1, ULA_OUT=0, no operand consumed.
REQ-014 SHALL capture A (first popped, TOS) in WAIT_A and B in WAIT_B, one operand per OPERAND_VALID cycle.
REQ-015 SHALL skip WAIT_B for unary ops (NOT, NEG).
REQ-016 SHALL ignore OPERAND_VALID in IDLE, EXEC and DONE.
REQ-017 SHALL compute result = B op A: 0 ADD, 1 SUB (B-A), 2 AND, 3 OR, 4 XOR, 5 NOT (~A), 6 NEG (-A), 7 SHL, 8 SHR logical, 9 EQ, 10 LTU (B<A unsigned), 11 MUL; codes 12-15 invalid.
REQ-018 SHALL for shifts use A as amount; A >= DATA_WIDTH yields 0.
REQ-019 SHALL return 1 or 0 (zero-extended) for EQ and LTU.
REQ-020 SHALL truncate all results to DATA_WIDTH (wrap-around).
REQ-021 SHALL set FLAG_CARRY = carry-out for ADD, borrow (B<A) for SUB, nonzero upper half for MUL, 0 otherwise.
REQ-022 SHALL set FLAG_ZERO = (ULA_OUT == 0), updated with ULA_OUT.
REQ-023 SHALL, for single-cycle ops, spend one cycle in EXEC: last operand at cycle N -> EXEC N+1 -> DONE N+2.
REQ-024 SHALL assert ULA_DONE for exactly one cycle (DONE), with ULA_OUT and flags valid that cycle, then return to IDLE.
REQ-025 SHALL hold ULA_OUT, flags and ERR_OP until the next DONE; ERR_OP cleared on next accepted OP_START.

Reset
REQ-026 SHALL on reset go to IDLE and clear ULA_OUT, ULA_DONE, FLAG_ZERO, FLAG_CARRY, ERR_OP and operand registers to 0, including mid-operation.
REQ-027 SHALL accept OP_START in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL compile MUL in only when macro STACK_ALU_MUL_EN is defined.
REQ-029 SHALL with STACK_ALU_MUL_EN implement MUL as shift-add, EXEC lasting DATA_WIDTH cycles: DONE at N+1+DATA_WIDTH.
REQ-030 SHALL without STACK_ALU_MUL_EN treat opcode 11 as invalid per REQ-013.

Structure
REQ-031 SHALL place opcode enum, FSM state enum and OP_WIDTH=4 in shared package stack_alu_pkg.
REQ-032 SHALL place the multiplier in sub-module stack_alu_mul_seq (start/done, DATA_WIDTH-cycle iteration), instantiated only under STACK_ALU_MUL_EN.

Verification (DATA_WIDTH=8)
REQ-033 SHALL cover ADD: A=0x05, B=0xFE -> ULA_OUT=0x03, CARRY=1, ZERO=0, ULA_DONE at N+2.
REQ-034 SHALL cover SUB: A=0x07, B=0x03 -> ULA_OUT=0xFC, CARRY=1; then A=0x03, B=0x03 -> 0x00, ZERO=1, CARRY=0.
REQ-035 SHALL cover NOT: A=0x0F -> ULA_OUT=0xF0 at N+2; an extra OPERAND_VALID in EXEC is not consumed.
REQ-036 SHALL cover MUL: A=0x10, B=0x11 -> with macro ULA_OUT=0x10, CARRY=1, done at N+9; without macro ERR_OP=1, ULA_OUT=0.
REQ-037 SHALL cover invalid opcode 0xF at cycle T -> ULA_DONE=1, ERR_OP=1 at T+1; OP_START during BUSY ignored.
REQ-038 SHALL cover reset asserted in WAIT_B -> next cycle ULA_BUSY=0, ULA_OUT=0; new ADD afterwards completes correctly.
